// File: rtl/btn_pkg.sv
// btn_pkg: shared state type, limits and ms-to-cycle helper for the push-button front end.
package btn_pkg;
  localparam int MAX_BTNS = 16;
  typedef enum logic [1:0] {IDLE, HELD, LONG} btn_state_t;
  // 64-bit so that e.g. 50 MHz * 5000 ms does not overflow
  function automatic logic [63:0] ms_to_cycles(input logic [63:0] clock_hz, input logic [63:0] ms);
    return clock_hz / 64'd1000 * ms;
  endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce and short/long/repeat press classification for one button.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_MS       = 5000,
  parameter int unsigned REPEAT_MS     = 0,
  parameter int unsigned TOGGLE_INIT   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic toggle
);
  localparam logic [63:0] DEB_CYC  = ms_to_cycles(64'(CLOCK_RATE_HZ), 64'(DEBOUNCE_MS));
  localparam logic [63:0] LONG_CYC = ms_to_cycles(64'(CLOCK_RATE_HZ), 64'(LONG_MS));
  localparam logic [63:0] RPT_CYC  = ms_to_cycles(64'(CLOCK_RATE_HZ), 64'(REPEAT_MS));
  localparam int DW = DEB_CYC > 64'd1 ? $clog2(DEB_CYC + 64'd1) : 1;
  localparam int HW = LONG_CYC > 64'd1 ? $clog2(LONG_CYC + 64'd1) : 1;
  localparam int RW = RPT_CYC > 64'd1 ? $clog2(RPT_CYC + 64'd1) : 1;
  localparam logic [DW-1:0] DEB_END  = DW'(DEB_CYC - 64'd1);
  localparam logic [HW-1:0] HOLD_END = HW'(LONG_CYC - 64'd1);
  localparam logic [RW-1:0] RPT_END  = RW'(RPT_CYC - 64'd1);
  localparam logic AL  = ACTIVE_LOW != 0;
  localparam logic TGL = TOGGLE_INIT != 0;

  if (DEBOUNCE_MS == 0 || LONG_MS == 0 || DEB_CYC == 64'd0 || LONG_CYC <= DEB_CYC) begin : g_bad_cfg
    $error("btn_channel: DEBOUNCE_MS and LONG_MS must be nonzero and LONG_CYC must exceed DEB_CYC");
  end

  logic [1:0]    sync_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  btn_state_t    state_q, state_d;
  logic pressed_q, pressed_d, short_q, short_d, long_q, long_d, rep_q, rep_d, toggle_q, toggle_d;
  logic lvl, deb_hit, rpt_hit;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q    <= {2{AL}};
      deb_q     <= '0;
      hold_q    <= '0;
      rpt_q     <= '0;
      state_q   <= IDLE;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      toggle_q  <= TGL;
    end else begin
      sync_q    <= {sync_q[0], btn_raw};
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      pressed_q <= pressed_d;
      short_q   <= short_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      toggle_q  <= toggle_d;
    end

  // The FSM follows pressed_d so that long_pulse lands exactly LONG_CYC cycles after the pressed rise
  always_comb begin
    lvl       = sync_q[1] ^ AL;
    deb_hit   = (lvl != pressed_q) && (deb_q == DEB_END);
    pressed_d = deb_hit ? lvl : pressed_q;
    deb_d     = (lvl != pressed_q && !deb_hit) ? deb_q + DW'(1) : '0;
    rpt_hit   = (RPT_CYC != 64'd0) && (rpt_q == RPT_END);
    state_d   = state_q;
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    rep_d     = 1'b0;
    toggle_d  = toggle_q;
    case (state_q)
      IDLE: begin
        state_d = pressed_d ? HELD : IDLE;
        hold_d  = '0;
      end
      HELD:
        if (hold_q == HOLD_END) begin
          state_d  = LONG;
          long_d   = 1'b1;
          toggle_d = ~toggle_q;
          rpt_d    = '0;
        end else if (!pressed_d) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else
          hold_d = hold_q + HW'(1);
      LONG: begin
        rep_d   = rpt_hit;
        rpt_d   = (RPT_CYC == 64'd0 || rpt_hit) ? '0 : rpt_q + RW'(1);
        state_d = pressed_d ? LONG : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pressed      = pressed_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign toggle       = toggle_q;
endmodule

// File: rtl/btn_press_detector.sv
// btn_press_detector: multi-channel push-button front end, one independent btn_channel per pin.
module btn_press_detector
  import btn_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
  parameter int unsigned NUM_BTNS      = 2,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_MS       = 5000,
  parameter int unsigned REPEAT_MS     = 0,
  parameter int unsigned TOGGLE_INIT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] pressed,
  output logic [NUM_BTNS-1:0] short_pulse,
  output logic [NUM_BTNS-1:0] long_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse,
  output logic [NUM_BTNS-1:0] toggle
);
  if (NUM_BTNS < 1 || NUM_BTNS > MAX_BTNS) begin : g_bad_num
    $error("btn_press_detector: NUM_BTNS must be in 1..16");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_channel #(
      .CLOCK_RATE_HZ(CLOCK_RATE_HZ),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_MS  (DEBOUNCE_MS),
      .LONG_MS      (LONG_MS),
      .REPEAT_MS    (REPEAT_MS),
      .TOGGLE_INIT  (TOGGLE_INIT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .pressed     (pressed[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .repeat_pulse(repeat_pulse[i]),
      .toggle      (toggle[i])
    );
  end
endmodule

// File: tb/tb_btn_press_detector.sv
// tb_btn_press_detector: table vectors, timed corner sequences and random pin activity vs a press-timeline model.
module tb_btn_press_detector;
  localparam int NB = 2, DEB = 4, LONG = 20, RPT = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NB-1:0] btn_raw = 2'b11;
  logic [NB-1:0] pressed, short_pulse, long_pulse, repeat_pulse, toggle;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  btn_press_detector #(
    .CLOCK_RATE_HZ(1000), .NUM_BTNS(NB), .ACTIVE_LOW(1), .DEBOUNCE_MS(DEB),
    .LONG_MS(LONG), .REPEAT_MS(RPT), .TOGGLE_INIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .pressed(pressed), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .toggle(toggle)
  );

  // Model: the pin reaches the debouncer two edges late; a press is a (rise, fall) interval on the
  // debounced level, and pulses are placed by the elapsed time since the rise.
  logic m_s1[NB], m_s2[NB], m_p[NB], m_tog[NB], e_s[NB], e_l[NB], e_r[NB];
  int m_run[NB], m_rise[NB], cnt_s[NB], cnt_l[NB], cnt_r[NB];
  int now = 0;

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_p[c] = 1'b0; m_tog[c] = 1'b1;
      e_s[c] = 1'b0; e_l[c] = 1'b0; e_r[c] = 1'b0; m_run[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic lvl, was;
    int d;
    now++;
    if (!rst_n) model_reset();
    else for (int c = 0; c < NB; c++) begin
      lvl = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = ~btn_raw[c];
      was = m_p[c];
      if (lvl != m_p[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin m_p[c] = lvl; m_run[c] = 0; end
      end else m_run[c] = 0;
      e_s[c] = 1'b0; e_l[c] = 1'b0; e_r[c] = 1'b0;
      if (!was && m_p[c]) m_rise[c] = now;
      if (was) begin
        d = now - m_rise[c];
        e_l[c] = (d == LONG);
        e_s[c] = !m_p[c] && d < LONG;
        e_r[c] = d > LONG && (d - LONG) % RPT == 0;
        if (d == LONG) m_tog[c] = ~m_tog[c];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [NB-1:0] ep, es, el, er, et;
    for (int c = 0; c < NB; c++) begin
      ep[c] = m_p[c]; es[c] = e_s[c]; el[c] = e_l[c]; er[c] = e_r[c]; et[c] = m_tog[c];
    end
    check("pressed", 32'(pressed), 32'(ep));
    check("short_pulse", 32'(short_pulse), 32'(es));
    check("long_pulse", 32'(long_pulse), 32'(el));
    check("repeat_pulse", 32'(repeat_pulse), 32'(er));
    check("toggle", 32'(toggle), 32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    for (int c = 0; c < NB; c++) begin
      cnt_s[c] += int'(short_pulse[c]);
      cnt_l[c] += int'(long_pulse[c]);
      cnt_r[c] += int'(repeat_pulse[c]);
    end
  endtask

  // sel: 0 = pressed[0], 1 = long_pulse[0], 2 = repeat_pulse[0]
  task automatic wait_sig(input int sel, input int limit, output int n);
    logic hit;
    n = 0;
    do begin
      step();
      n++;
      hit = sel == 0 ? pressed[0] : sel == 1 ? long_pulse[0] : repeat_pulse[0];
    end while (!hit && n < limit);
  endtask

  typedef struct packed {
    logic [7:0] n0, n1;
    logic [3:0] s0, l0, r0, s1, l1, r1;
    logic [1:0] tog;
  } vec_t;

  vec_t vecs [8];
  int n, dur[NB];

  initial begin
    vecs[0] = '{8'd3,  8'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11};
    vecs[1] = '{8'd10, 8'd0,  4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11};
    vecs[2] = '{8'd40, 8'd0,  4'd0, 4'd1, 4'd4, 4'd0, 4'd0, 4'd0, 2'b10};
    vecs[3] = '{8'd20, 8'd0,  4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11};
    vecs[4] = '{8'd19, 8'd0,  4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11};
    vecs[5] = '{8'd4,  8'd0,  4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11};
    vecs[6] = '{8'd8,  8'd30, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 2'b01};
    vecs[7] = '{8'd25, 8'd25, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 2'b10};

    model_reset();
    repeat (3) step();
    check("reset_pressed", 32'(pressed), 0);
    check("reset_toggle", 32'(toggle), 32'h3);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int c = 0; c < NB; c++) begin cnt_s[c] = 0; cnt_l[c] = 0; cnt_r[c] = 0; end
      for (int k = 0; k < int'(vecs[i].n0 > vecs[i].n1 ? vecs[i].n0 : vecs[i].n1) + 12; k++) begin
        btn_raw[0] = !(k < int'(vecs[i].n0));
        btn_raw[1] = !(k < int'(vecs[i].n1));
        step();
      end
      check($sformatf("v%0d_short0", i), 32'(cnt_s[0]), 32'(vecs[i].s0));
      check($sformatf("v%0d_long0", i), 32'(cnt_l[0]), 32'(vecs[i].l0));
      check($sformatf("v%0d_rpt0", i), 32'(cnt_r[0]), 32'(vecs[i].r0));
      check($sformatf("v%0d_short1", i), 32'(cnt_s[1]), 32'(vecs[i].s1));
      check($sformatf("v%0d_long1", i), 32'(cnt_l[1]), 32'(vecs[i].l1));
      check($sformatf("v%0d_rpt1", i), 32'(cnt_r[1]), 32'(vecs[i].r1));
      check($sformatf("v%0d_toggle", i), 32'(toggle), 32'(vecs[i].tog));
    end

    cnt_s[0] = 0;
    btn_raw = 2'b10;
    wait_sig(0, 20, n);
    check("rise_latency", n, 6);
    wait_sig(1, 40, n);
    check("long_after_rise", n, 20);
    wait_sig(2, 20, n);
    check("repeat_first", n, 5);
    wait_sig(2, 20, n);
    check("repeat_second", n, 5);
    btn_raw = 2'b11;
    repeat (20) step();
    check("no_short_after_long", cnt_s[0], 0);

    btn_raw = 2'b10;
    wait_sig(0, 20, n);
    check("rise_before_reset", n, 6);
    repeat (10) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_pressed", 32'(pressed), 0);
    check("rst_async_pulses", 32'({short_pulse, long_pulse, repeat_pulse}), 0);
    check("rst_async_toggle", 32'(toggle), 32'h3);
    repeat (2) step();
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    check("rise_after_reset", n, 6);
    wait_sig(1, 40, n);
    check("long_after_reset", n, 20);
    btn_raw = 2'b11;
    repeat (20) step();

    for (int c = 0; c < NB; c++) dur[c] = int'($urandom_range(1, 45));
    repeat (3000) begin
      for (int c = 0; c < NB; c++) begin
        dur[c]--;
        if (dur[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          dur[c] = int'($urandom_range(1, 45));
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
